// File: rtl/circle_sort_pkg.sv
// -----------------------------------------------------------------------------
// circle_sort_pkg
// Shared definitions for the circle-rotate/sum/sort engine protocol: frame and
// result geometry, host FSM state encoding and the error codes reported by the
// host (also used by engine-side RTL and benches).
// No ports (package).
// -----------------------------------------------------------------------------
package circle_sort_pkg;

  localparam int NUM_PIX = 8;
  localparam int PIX_W   = 5;
  localparam int SUM_W   = 6;
  localparam int CHK_W   = 9;
  localparam int IDX_W   = 3;
  localparam int FRAME_W = NUM_PIX * PIX_W;
  localparam int RES_W   = NUM_PIX * SUM_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND1 = 3'd1,
    ST_SEND2 = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RECV  = 3'd4,
    ST_CHECK = 3'd5,
    ST_DONE  = 3'd6
  } csh_state_e;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_EARLY   = 3'd1;
  localparam logic [2:0] ERR_TIMEOUT = 3'd2;
  localparam logic [2:0] ERR_GAP     = 3'd3;
  localparam logic [2:0] ERR_ORDER   = 3'd4;
  localparam logic [2:0] ERR_CHKSUM  = 3'd5;

  // Pixel i of a packed frame; pixel 0 sits in the low bits.
  function automatic logic [PIX_W-1:0] frame_pix(input logic [FRAME_W-1:0] f,
                                                 input logic [IDX_W-1:0]   i);
    return f[i*PIX_W +: PIX_W];
  endfunction

  // Only the first error of a transaction is reported.
  function automatic logic [2:0] keep_first_err(input logic [2:0] cur,
                                                input logic [2:0] nxt);
    return (cur == ERR_NONE) ? nxt : cur;
  endfunction

endpackage

// File: rtl/circle_sort_host_rx_checker.sv
// -----------------------------------------------------------------------------
// csh_rx_checker
// Receive side of circle_sort_host: stores the 8 result beats, flags a beat
// that is smaller than its predecessor, and (with CSH_CHECKSUM_EN defined)
// compares the sum of received beats against the sum of all transmitted pixels.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr             clear stored beats/accumulator (accepted start)
//   cap, idx, beat  capture beat 'beat' into slot 'idx' this cycle
//   frame1, frame2  latched frames (only with CSH_CHECKSUM_EN)
//   result          captured beats, beat k at [6k+5:6k]
//   order_bad       combinational: beat being captured is below the previous one
//   sum_bad         combinational: checksum mismatch (always 0 without the macro)
// -----------------------------------------------------------------------------
module csh_rx_checker
  import circle_sort_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               cap,
  input  logic [IDX_W-1:0]   idx,
  input  logic [SUM_W-1:0]   beat,
`ifdef CSH_CHECKSUM_EN
  input  logic [FRAME_W-1:0] frame1,
  input  logic [FRAME_W-1:0] frame2,
`endif
  output logic [RES_W-1:0]   result,
  output logic               order_bad,
  output logic               sum_bad
);

  logic [RES_W-1:0] result_q, result_d;
  logic [IDX_W-1:0] prev_idx;
  logic [SUM_W-1:0] prev_beat;

  always_comb begin
    result_d = result_q;
    if (clr) begin
      result_d = '0;
    end else if (cap) begin
      result_d[idx*SUM_W +: SUM_W] = beat;
    end
  end

  // Beats arrive on consecutive cycles, so slot idx-1 already holds the
  // predecessor when beat idx is presented.
  assign prev_idx  = idx - 1'b1;
  assign prev_beat = result_q[prev_idx*SUM_W +: SUM_W];
  assign order_bad = cap && (idx != '0) && (beat < prev_beat);
  assign result    = result_q;

`ifdef CSH_CHECKSUM_EN
  logic [CHK_W-1:0] acc_q, acc_d;
  logic [CHK_W-1:0] pix_sum;

  // Rotation only permutes pixels, so the beat total must equal the pixel total.
  always_comb begin
    pix_sum = '0;
    for (int i = 0; i < NUM_PIX; i++) begin
      pix_sum = pix_sum + CHK_W'(frame1[i*PIX_W +: PIX_W])
                        + CHK_W'(frame2[i*PIX_W +: PIX_W]);
    end
  end

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (cap) begin
      acc_d = acc_q + CHK_W'(beat);
    end
  end

  assign sum_bad = (acc_q != pix_sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  assign sum_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
    end else begin
      result_q <= result_d;
    end
  end

endmodule

// File: rtl/circle_sort_host.sv
// -----------------------------------------------------------------------------
// circle_sort_host
// Initiator for the circle-rotate/sum/sort engine. On start it latches two
// 8-pixel frames and two rotation indices, streams 16 pixels to the engine,
// waits (bounded by TIMEOUT) for the 8-beat sorted result, checks it and
// reports pass/err with a one-cycle done pulse.
// Optional feature: define CSH_CHECKSUM_EN to add the pixel/beat checksum
// comparison (err=5); without it err=5 is never produced.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    1-cycle request, honoured only in IDLE
//   cfg_circle1/2            rotation indices, latched on start
//   frame1_data/frame2_data  packed pixels, pixel i at [5i+4:5i]
//   circle1/2, in, in_valid  engine input stream (all registered)
//   dut_out, dut_out_valid   engine result stream
//   busy, done, pass, err    status; pass/err held until next start
//   result                   captured beats, beat k at [6k+5:6k]
// -----------------------------------------------------------------------------
module circle_sort_host
  import circle_sort_pkg::*;
#(
  parameter int TIMEOUT = 100
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         cfg_circle1,
  input  logic [2:0]         cfg_circle2,
  input  logic [FRAME_W-1:0] frame1_data,
  input  logic [FRAME_W-1:0] frame2_data,
  output logic [2:0]         circle1,
  output logic [2:0]         circle2,
  output logic [PIX_W-1:0]   in,
  output logic               in_valid,
  input  logic [SUM_W-1:0]   dut_out,
  input  logic               dut_out_valid,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2:0]         err,
  output logic [RES_W-1:0]   result
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(NUM_PIX - 1);

  csh_state_e         state_q, state_d;
  logic [IDX_W-1:0]   beat_q, beat_d, nxt_beat;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] f1_q, f1_d, f2_q, f2_d;
  logic [2:0]         circle1_q, circle1_d, circle2_q, circle2_d;
  logic [PIX_W-1:0]   in_q, in_d;
  logic               in_valid_q, in_valid_d;
  logic               busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [2:0]         err_q, err_d;
  logic               to_done;

  logic               rx_clr, rx_cap, order_bad, sum_bad;

  assign nxt_beat = beat_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    cnt_d      = cnt_q;
    f1_d       = f1_q;
    f2_d       = f2_q;
    circle1_d  = 3'd0;
    circle2_d  = 3'd0;
    in_d       = '0;
    in_valid_d = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    pass_d     = pass_q;
    err_d      = err_q;
    to_done    = 1'b0;
    rx_clr     = 1'b0;
    rx_cap     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Outputs are registered, so beat 0 is taken straight from the ports.
          state_d    = ST_SEND1;
          beat_d     = '0;
          f1_d       = frame1_data;
          f2_d       = frame2_data;
          circle1_d  = cfg_circle1;
          circle2_d  = cfg_circle2;
          in_d       = frame_pix(frame1_data, '0);
          in_valid_d = 1'b1;
          busy_d     = 1'b1;
          pass_d     = 1'b0;
          err_d      = ERR_NONE;
          rx_clr     = 1'b1;
        end
      end

      ST_SEND1: begin
        if (dut_out_valid) begin
          err_d   = keep_first_err(err_q, ERR_EARLY);
          to_done = 1'b1;
        end else if (beat_q == LAST_BEAT) begin
          state_d    = ST_SEND2;
          beat_d     = '0;
          in_d       = frame_pix(f2_q, '0);
          in_valid_d = 1'b1;
        end else begin
          beat_d     = nxt_beat;
          in_d       = frame_pix(f1_q, nxt_beat);
          in_valid_d = 1'b1;
        end
      end

      ST_SEND2: begin
        if (dut_out_valid) begin
          err_d   = keep_first_err(err_q, ERR_EARLY);
          to_done = 1'b1;
        end else if (beat_q == LAST_BEAT) begin
          state_d = ST_WAIT;
          beat_d  = '0;
          cnt_d   = '0;
        end else begin
          beat_d     = nxt_beat;
          in_d       = frame_pix(f2_q, nxt_beat);
          in_valid_d = 1'b1;
        end
      end

      ST_WAIT: begin
        // A valid on the last permitted wait cycle still counts as on time.
        if (dut_out_valid) begin
          rx_cap  = 1'b1;
          state_d = ST_RECV;
          beat_d  = 3'd1;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = keep_first_err(err_q, ERR_TIMEOUT);
          to_done = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RECV: begin
        if (dut_out_valid) begin
          rx_cap = 1'b1;
          if (order_bad) begin
            err_d = keep_first_err(err_q, ERR_ORDER);
          end
          if (beat_q == LAST_BEAT) begin
            state_d = ST_CHECK;
          end else begin
            beat_d = nxt_beat;
          end
        end else begin
          err_d   = keep_first_err(err_q, ERR_GAP);
          to_done = 1'b1;
        end
      end

      ST_CHECK: begin
        if (dut_out_valid) begin
          err_d = keep_first_err(err_q, ERR_GAP);
        end else if (sum_bad) begin
          err_d = keep_first_err(err_q, ERR_CHKSUM);
        end
        to_done = 1'b1;
      end

      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (to_done) begin
      state_d = ST_DONE;
      done_d  = 1'b1;
      pass_d  = (err_d == ERR_NONE);
    end
  end

  // ---- control / output register stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      beat_q     <= '0;
      cnt_q      <= '0;
      circle1_q  <= 3'd0;
      circle2_q  <= 3'd0;
      in_q       <= '0;
      in_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      circle1_q  <= circle1_d;
      circle2_q  <= circle2_d;
      in_q       <= in_d;
      in_valid_q <= in_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
    end
  end

  // ---- latched frame data (no reset needed; loaded on every start) ----
  always_ff @(posedge clk) begin
    f1_q <= f1_d;
    f2_q <= f2_d;
  end

  csh_rx_checker u_rx (
    .clk       (clk),
    .rst       (rst),
    .clr       (rx_clr),
    .cap       (rx_cap),
    .idx       (beat_q),
    .beat      (dut_out),
`ifdef CSH_CHECKSUM_EN
    .frame1    (f1_q),
    .frame2    (f2_q),
`endif
    .result    (result),
    .order_bad (order_bad),
    .sum_bad   (sum_bad)
  );

  assign circle1  = circle1_q;
  assign circle2  = circle2_q;
  assign in       = in_q;
  assign in_valid = in_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign err      = err_q;

endmodule

// File: tb/tb_circle_sort_host.sv
// -----------------------------------------------------------------------------
// tb_circle_sort_host
// Directed bench for circle_sort_host. The stimulus process acts as the host's
// user and as a behavioural engine (latency, beat list, faults); expected
// transaction outcomes go into a queue that a negedge monitor pops on done.
// -----------------------------------------------------------------------------
module tb_circle_sort_host;

  localparam int TIMEOUT = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  cfg_circle1 = '0, cfg_circle2 = '0;
  logic [39:0] frame1_data = '0, frame2_data = '0;
  logic [2:0]  circle1, circle2;
  logic [4:0]  in;
  logic        in_valid;
  logic [5:0]  dut_out = '0;
  logic        dut_out_valid = 1'b0;
  logic        busy, done, pass;
  logic [2:0]  err;
  logic [47:0] result;

  circle_sort_host #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_circle1(cfg_circle1), .cfg_circle2(cfg_circle2),
    .frame1_data(frame1_data), .frame2_data(frame2_data),
    .circle1(circle1), .circle2(circle2), .in(in), .in_valid(in_valid),
    .dut_out(dut_out), .dut_out_valid(dut_out_valid),
    .busy(busy), .done(done), .pass(pass), .err(err), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int          cyc;
    logic [2:0]  err;
    logic        pass;
    logic [47:0] result;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [5:0] beats [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] ramp();
    logic [39:0] f;
    for (int i = 0; i < 8; i++) f[i*5 +: 5] = 5'(i);
    return f;
  endfunction

  function automatic logic [39:0] fill(input logic [4:0] v);
    logic [39:0] f;
    for (int i = 0; i < 8; i++) f[i*5 +: 5] = v;
    return f;
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_done: got done at cycle %0d required none", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
        chk("err", 64'(err), 64'(mon_e.err));
        chk("pass", 64'(pass), 64'(mon_e.pass));
        chk("result", 64'(result), 64'(mon_e.result));
        chk("busy_at_done", 64'(busy), 64'd1);
      end
    end
  end

  // One transaction. lat: first result beat lat cycles after last in_valid beat.
  // nb: beats the engine returns (0 silent, <8 gap, 9 overrun).
  // early_k / rst_k: tx beat index at which the engine fires early / rst pulses (-1 off).
  task automatic run(input string name, input logic [39:0] f1, input logic [39:0] f2,
                     input logic [2:0] c1, input logic [2:0] c2, input int lat,
                     input int nb, input int early_k, input int rst_k,
                     input logic [2:0] xerr);
    int   t0;
    int   w;
    logic tx_bad;
    logic [4:0] px;
    logic [2:0] e1, e2;
    exp_t e;
    bit   stop;

    @(posedge clk); #1;
    frame1_data = f1; frame2_data = f2;
    cfg_circle1 = c1; cfg_circle2 = c2;
    start = 1'b1;
    t0 = cyc;

    w = t0 + 16 + lat;
    e.err = xerr;
    e.pass = (xerr == 3'd0);
    e.result = '0;
    if (early_k >= 0)   e.cyc = t0 + early_k + 2;
    else if (nb == 0)   e.cyc = t0 + 17 + TIMEOUT;
    else if (nb < 8)    e.cyc = w + nb + 1;
    else                e.cyc = w + 9;
    if (early_k < 0) begin
      for (int j = 0; j < nb && j < 8; j++) e.result[j*6 +: 6] = beats[j];
    end
    if (rst_k < 0) sb.push_back(e);

    @(posedge clk); #1;
    start = 1'b0;
    // Inputs change after start; the host must keep what it latched.
    frame1_data = ~f1; frame2_data = ~f2;
    cfg_circle1 = ~c1; cfg_circle2 = ~c2;

    tx_bad = 1'b0;
    stop = 1'b0;
    for (int k = 0; k < 16 && !stop; k++) begin
      px = (k < 8) ? f1[k*5 +: 5] : f2[(k-8)*5 +: 5];
      e1 = (k == 0) ? c1 : 3'd0;
      e2 = (k == 0) ? c2 : 3'd0;
      if (in_valid !== 1'b1 || in !== px || circle1 !== e1 || circle2 !== e2) tx_bad = 1'b1;
      if (k == rst_k) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk({name, "/rst_abort"}, 64'({in_valid, busy, done}), 64'd0);
        stop = 1'b1;
      end else if (k == early_k) begin
        dut_out_valid = 1'b1;
        dut_out = 6'd9;
        @(posedge clk); #1;
        dut_out_valid = 1'b0;
        dut_out = '0;
        chk({name, "/early_drop"}, 64'(in_valid), 64'd0);
        stop = 1'b1;
      end else begin
        @(posedge clk); #1;
      end
    end
    chk({name, "/tx_stream"}, 64'(tx_bad), 64'd0);

    if (!stop) begin
      chk({name, "/in_idle"}, 64'({in_valid, in, circle1, circle2}), 64'd0);
      for (int d = 1; d < lat; d++) begin
        @(posedge clk); #1;
      end
      for (int j = 0; j < nb; j++) begin
        dut_out_valid = 1'b1;
        dut_out = beats[j];
        @(posedge clk); #1;
      end
      dut_out_valid = 1'b0;
      dut_out = '0;
    end

    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s/done_wait: got no done required done by cycle %0d", name, e.cyc);
      sb.delete();
    end else begin
      chk({name, "/busy_after"}, 64'(busy), 64'd0);
      if (rst_k < 0) chk({name, "/held"}, 64'({pass, err}), 64'({e.pass, e.err}));
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", 64'({busy, done, pass, err, in_valid, in, circle1, circle2}), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    rst = 1'b0;

    beats = '{6'd62, 6'd62, 6'd62, 6'd62, 6'd62, 6'd62, 6'd62, 6'd62, 6'd0};
    run("all31", fill(5'd31), fill(5'd31), 3'd0, 3'd0, 3, 8, -1, -1, 3'd0);

    beats = '{6'd0, 6'd2, 6'd4, 6'd6, 6'd8, 6'd10, 6'd12, 6'd14, 6'd63};
    run("ramp", ramp(), ramp(), 3'd0, 3'd0, 3, 8, -1, -1, 3'd0);

    beats = '{6'd4, 6'd4, 6'd6, 6'd6, 6'd8, 6'd8, 6'd10, 6'd10, 6'd0};
    run("rot26", ramp(), ramp(), 3'd2, 3'd6, 5, 8, -1, -1, 3'd0);

    run("timeout", ramp(), ramp(), 3'd1, 3'd1, 1, 0, -1, -1, 3'd2);

    run("early", ramp(), ramp(), 3'd0, 3'd0, 3, 8, 11, -1, 3'd1);

    beats = '{6'd2, 6'd4, 6'd3, 6'd5, 6'd6, 6'd7, 6'd8, 6'd9, 6'd0};
    run("unsorted", ramp(), ramp(), 3'd0, 3'd0, 3, 8, -1, -1, 3'd4);

    beats = '{6'd0, 6'd2, 6'd4, 6'd6, 6'd8, 6'd10, 6'd12, 6'd15, 6'd0};
`ifdef CSH_CHECKSUM_EN
    run("checksum", ramp(), ramp(), 3'd0, 3'd0, 3, 8, -1, -1, 3'd5);
`else
    run("checksum", ramp(), ramp(), 3'd0, 3'd0, 3, 8, -1, -1, 3'd0);
`endif

    beats = '{6'd0, 6'd2, 6'd4, 6'd6, 6'd8, 6'd10, 6'd12, 6'd14, 6'd63};
    run("late_edge", ramp(), ramp(), 3'd0, 3'd0, TIMEOUT, 8, -1, -1, 3'd0);
    run("gap", ramp(), ramp(), 3'd0, 3'd0, 2, 5, -1, -1, 3'd3);
    run("overrun", ramp(), ramp(), 3'd0, 3'd0, 2, 9, -1, -1, 3'd3);

    run("rst_mid", ramp(), ramp(), 3'd0, 3'd0, 3, 8, -1, 4, 3'd0);
    beats = '{6'd62, 6'd62, 6'd62, 6'd62, 6'd62, 6'd62, 6'd62, 6'd62, 6'd0};
    run("after_rst", fill(5'd31), fill(5'd31), 3'd3, 3'd5, 3, 8, -1, -1, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
